abus_master_sequencer: RTL

// - Saturn A-bus initiator: turns one command handshake into one fixed-timing A-bus read/write cycle.
// - Drives address, CS0..CS2, RD and per-byte WR strobes, and samples the read data.
// - Bench/loopback master for the cartridge-side abus_avalon_sdram_bridge. Sits between an Avalon-style command source and the A-bus pins.

---
 rtl/abus_pkg.sv | 30 +++
 rtl/abus_sync2.sv | 22 ++
 rtl/abus_master_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/abus_pkg.sv
// Shared types and constants for the A-bus master sequencer.
package abus_pkg;

   localparam int         ABUS_ADDR_W = 25;
   localparam int         ABUS_DATA_W = 16;
   localparam logic [1:0] CS_ILLEGAL  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      TURN
   } state_t;

   // Command fields captured at acceptance
   typedef struct packed {
      logic                   write;
      logic [1:0]             cs;
      logic [ABUS_ADDR_W-1:0] address;
      logic [ABUS_DATA_W-1:0] writedata;
      logic [1:0]             byteenable;
   } cmd_t;

   // Active-low one-hot chip select for CS0..CS2 (bit i = CSi)
   function automatic logic [2:0] cs_decode(input logic [1:0] cs);
      return ~(3'b001 << cs);
   endfunction

endpackage

// File: rtl/abus_sync2.sv
// Two-flop synchroniser for the asynchronous A-bus interrupt line.
module abus_sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; meta absorbs metastability
   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/abus_master_sequencer.sv
// Saturn A-bus initiator: one accepted command becomes one fixed-timing
// SETUP/STROBE/HOLD/TURN bus cycle with all pin outputs registered.
module abus_master_sequencer
   import abus_pkg::*;
#(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 6,
   parameter int HOLD_CYCLES   = 2,
   parameter int TURN_CYCLES   = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [1:0]             cmd_cs,
   input  logic [ABUS_ADDR_W-1:0] cmd_address,
   input  logic [ABUS_DATA_W-1:0] cmd_writedata,
   input  logic [1:0]             cmd_byteenable,
   output logic                   rsp_valid,
   output logic [ABUS_DATA_W-1:0] rsp_readdata,
   output logic                   rsp_error,
   output logic [ABUS_ADDR_W-1:0] abus_address,
   output logic [2:0]             abus_chipselect_n,
   output logic                   abus_read_n,
   output logic [1:0]             abus_writebyteenable_n,
   output logic [ABUS_DATA_W-1:0] abus_data_out,
   output logic                   abus_data_oe,
   input  logic [ABUS_DATA_W-1:0] abus_data_in,
   input  logic                   abus_direction,
   input  logic                   abus_interrupt,
   output logic                   irq
);

   // Counter reload values: a state with N cycles counts N-1 down to 0
   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   cmd_t cmd_in, cmd_q, cmd_src;
   logic accept, illegal, last_strobe, contention;

   logic [ABUS_ADDR_W-1:0] addr_nxt;
   logic [2:0]             cs_n_nxt;
   logic                   rd_n_nxt;
   logic [1:0]             wbe_n_nxt;
   logic [ABUS_DATA_W-1:0] dout_nxt;
   logic                   oe_nxt;

   assign accept      = cmd_valid & cmd_ready;
   assign illegal     = (cmd_cs == CS_ILLEGAL);
   assign last_strobe = (state == STROBE) && (cnt == 4'd0);

   assign cmd_in = '{write:      cmd_write,
                     cs:         cmd_cs,
                     address:    cmd_address,
                     writedata:  cmd_writedata,
                     byteenable: cmd_byteenable};

   // Pin values for the SETUP entry come straight from the inputs; later
   // states use the captured copy
   assign cmd_src = accept ? cmd_in : cmd_q;

   abus_sync2 u_irq_sync (
      .clock (clock),
      .reset (reset),
      .d     (abus_interrupt),
      .q     (irq)
   );

   // State register and shared down-counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: each timed state exits when the counter reaches zero
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept && !illegal) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = STROBE;
               cnt_nxt   = STROBE_LD;
            end else cnt_nxt = cnt - 4'd1;
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LD;
            end else cnt_nxt = cnt - 4'd1;
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt = TURN;
               cnt_nxt   = TURN_LD;
            end else cnt_nxt = cnt - 4'd1;
         end
         TURN: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end else cnt_nxt = cnt - 4'd1;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Pin values for the upcoming state, so registered pins line up with it
   always_comb begin
      addr_nxt  = abus_address;
      cs_n_nxt  = abus_chipselect_n;
      rd_n_nxt  = 1'b1;
      wbe_n_nxt = 2'b11;
      dout_nxt  = abus_data_out;
      oe_nxt    = abus_data_oe;
      case (state_nxt)
         IDLE: begin
            cs_n_nxt = 3'b111;
            oe_nxt   = 1'b0;
         end
         SETUP: begin
            addr_nxt = cmd_src.address;
            cs_n_nxt = cs_decode(cmd_src.cs);
            oe_nxt   = cmd_src.write;
            if (cmd_src.write) dout_nxt = cmd_src.writedata;
         end
         STROBE: begin
            rd_n_nxt  = cmd_src.write;
            wbe_n_nxt = cmd_src.write ? ~cmd_src.byteenable : 2'b11;
         end
         HOLD: begin
            // address, CS and write data held
         end
         TURN: begin
            cs_n_nxt = 3'b111;
            oe_nxt   = 1'b0;
         end
         default: begin
            cs_n_nxt = 3'b111;
            oe_nxt   = 1'b0;
         end
      endcase
   end

   // Pin registers, command capture, contention flag and response
   always_ff @(posedge clock) begin
      if (reset) begin
         abus_address           <= '0;
         abus_chipselect_n      <= 3'b111;
         abus_read_n            <= 1'b1;
         abus_writebyteenable_n <= 2'b11;
         abus_data_out          <= '0;
         abus_data_oe           <= 1'b0;
         cmd_ready              <= 1'b0;
         cmd_q                  <= '0;
         contention             <= 1'b0;
         rsp_valid              <= 1'b0;
         rsp_readdata           <= '0;
         rsp_error              <= 1'b0;
      end else begin
         abus_address           <= addr_nxt;
         abus_chipselect_n      <= cs_n_nxt;
         abus_read_n            <= rd_n_nxt;
         abus_writebyteenable_n <= wbe_n_nxt;
         abus_data_out          <= dout_nxt;
         abus_data_oe           <= oe_nxt;
         // An illegal command costs one not-ready cycle while it is answered
         cmd_ready              <= (state_nxt == IDLE) && !(accept && illegal);
         rsp_valid              <= 1'b0;

         if (accept) begin
            cmd_q      <= cmd_in;
            contention <= 1'b0;
         end else if (cmd_q.write && abus_direction &&
                      (state == SETUP || state == STROBE || state == HOLD)) begin
            contention <= 1'b1;
         end

         if (accept && illegal) begin
            rsp_valid    <= 1'b1;
            rsp_readdata <= '0;
            rsp_error    <= 1'b1;
         end else if (last_strobe) begin
            rsp_valid    <= 1'b1;
            rsp_readdata <= cmd_q.write ? '0 : abus_data_in;
            rsp_error    <= cmd_q.write && (contention || abus_direction);
         end
      end
   end

endmodule
